sdft_sequencer: RTL and testbench

- Upstream control stage for the sliding-DFT processing unit (SPU).
- Accepts one new time-domain sample at a time and keeps an FFT_SIZE-deep sample history.
- Computes sample_diff = x[n] - x[n-FFT_SIZE], then sweeps bins k = 0..FFT_SIZE-1. The sweep drives bin-RAM/twiddle-ROM read addresses and the SPU's sample_diff, idx and wr_en, time-aligned to the memory read latency.
- After reset, zeroes its own history RAM and the external bin RAM.

---
 rtl/sdft_pkg.sv | 19 +
 rtl/sdft_sequencer_if.sv | 33 +++
 rtl/sdft_delay_buf.sv | 32 +++
 rtl/sdft_hist_ram.sv | 29 ++
 rtl/sdft_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sdft_sequencer.sv | 160 ++++++++++++++++
 6 files changed

// File: rtl/sdft_pkg.sv
// Shared definitions for the sliding-DFT sequencer: FSM state encoding and default sizing.
// Build option SDFT_DIFF_SAT_EN (used in sdft_sequencer) selects saturating sample differences.
package sdft_pkg;

    localparam int WORD_WIDTH_DEFAULT  = 16;
    localparam int FFT_SIZE_DEFAULT    = 512;
    localparam int RD_LATENCY_DEFAULT  = 1;
    localparam int SPU_LATENCY_DEFAULT = 3;
    localparam int IDX_W               = $clog2(FFT_SIZE_DEFAULT);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        DIFF,
        SWEEP,
        DRAIN
    } sdft_state_e;

endpackage

// File: rtl/sdft_sequencer_if.sv
// Sample-input handshake plus the SPU / bin-RAM control bundle driven by the sequencer.
interface sdft_sequencer_if
    import sdft_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int FFT_SIZE   = FFT_SIZE_DEFAULT
);
    localparam int AW = $clog2(FFT_SIZE);

    logic signed [WORD_WIDTH-1:0] i_sample;
    logic                         i_valid;
    logic                         o_ready;
    logic        [AW-1:0]         o_rd_addr;
    logic signed [WORD_WIDTH-1:0] o_sample_diff;
    logic        [AW-1:0]         o_idx;
    logic                         o_wr_en;
    logic                         o_clr_en;
    logic        [AW-1:0]         o_clr_addr;
    logic                         o_frame_done;

    modport master (
        output i_sample, i_valid,
        input  o_ready, o_rd_addr, o_sample_diff, o_idx, o_wr_en,
               o_clr_en, o_clr_addr, o_frame_done
    );

    modport slave (
        input  i_sample, i_valid,
        output o_ready, o_rd_addr, o_sample_diff, o_idx, o_wr_en,
               o_clr_en, o_clr_addr, o_frame_done
    );

endinterface

// File: rtl/sdft_delay_buf.sv
// Resettable fixed-depth register delay line used to align control with memory read latency.
module sdft_delay_buf #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) q_reg <= '0;
                    else       q_reg <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (reset) q_reg <= '0;
                    else       q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/sdft_hist_ram.sv
// Single-port sample-history RAM with one-cycle registered read; maps onto block RAM.
module sdft_hist_ram
    import sdft_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int DEPTH      = FFT_SIZE_DEFAULT,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rdata_reg;

    // Reads and writes never target the same cycle in a way the sequencer cares about.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sdft_sequencer.sv
// Sliding-DFT control stage: history RAM, sample difference, bin sweep and writeback drain.
// Define SDFT_DIFF_SAT_EN to saturate the difference instead of wrapping it.
module sdft_sequencer
    import sdft_pkg::*;
#(
    parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
    parameter int FFT_SIZE    = FFT_SIZE_DEFAULT,
    parameter int RD_LATENCY  = RD_LATENCY_DEFAULT,
    parameter int SPU_LATENCY = SPU_LATENCY_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    sdft_sequencer_if.slave bus
);

    localparam int AW        = $clog2(FFT_SIZE);
    localparam int DRAIN_CYC = RD_LATENCY + SPU_LATENCY;
    localparam int DW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [AW-1:0] LAST_K = AW'(FFT_SIZE - 1);
    localparam logic [DW-1:0] LAST_D = DW'(DRAIN_CYC - 1);

    sdft_state_e                  state_reg, state_next;
    logic        [AW-1:0]         cnt_reg, cnt_next;
    logic        [DW-1:0]         drain_reg, drain_next;
    logic        [AW-1:0]         ptr_reg, ptr_next;
    logic                         clr_en_reg, clr_en_next;
    logic signed [WORD_WIDTH-1:0] sample_reg, sample_next;
    logic signed [WORD_WIDTH-1:0] diff_reg, diff_next;

    logic                         hist_we;
    logic        [AW-1:0]         hist_addr;
    logic        [WORD_WIDTH-1:0] hist_wdata;
    logic        [WORD_WIDTH-1:0] hist_rdata;
    logic signed [WORD_WIDTH:0]   diff_full;
    logic signed [WORD_WIDTH-1:0] diff_red;
    logic        [AW-1:0]         rd_addr;
    logic        [AW:0]           align_in;
    logic        [AW:0]           align_out;

    sdft_hist_ram #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (FFT_SIZE)
    ) u_hist_ram (
        .clk   (clk),
        .we    (hist_we),
        .addr  (hist_addr),
        .wdata (hist_wdata),
        .rdata (hist_rdata)
    );

    assign diff_full = {sample_reg[WORD_WIDTH-1], sample_reg}
                     - {hist_rdata[WORD_WIDTH-1], hist_rdata};

`ifdef SDFT_DIFF_SAT_EN
    // Overflow shows as disagreement between the two top bits of the wide difference.
    always_comb begin
        diff_red = diff_full[WORD_WIDTH-1:0];
        if (diff_full[WORD_WIDTH] != diff_full[WORD_WIDTH-1]) begin
            diff_red = diff_full[WORD_WIDTH] ? {1'b1, {(WORD_WIDTH-1){1'b0}}}
                                             : {1'b0, {(WORD_WIDTH-1){1'b1}}};
        end
    end
`else
    assign diff_red = diff_full[WORD_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= INIT;
            cnt_reg    <= '0;
            drain_reg  <= '0;
            ptr_reg    <= '0;
            clr_en_reg <= 1'b0;
            sample_reg <= '0;
            diff_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            drain_reg  <= drain_next;
            ptr_reg    <= ptr_next;
            clr_en_reg <= clr_en_next;
            sample_reg <= sample_next;
            diff_reg   <= diff_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        drain_next  = drain_reg;
        ptr_next    = ptr_reg;
        clr_en_next = clr_en_reg;
        sample_next = sample_reg;
        diff_next   = diff_reg;
        hist_we     = 1'b0;
        hist_addr   = ptr_reg;
        hist_wdata  = sample_reg;
        unique case (state_reg)
            INIT: begin
                hist_addr  = cnt_reg;
                hist_wdata = '0;
                // First cycle after reset only arms the clear strobe so it starts at address 0.
                if (!clr_en_reg) begin
                    clr_en_next = 1'b1;
                end else begin
                    hist_we  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_K) begin
                        clr_en_next = 1'b0;
                        state_next  = IDLE;
                    end
                end
            end
            IDLE: begin
                if (bus.i_valid) begin
                    sample_next = bus.i_sample;
                    state_next  = DIFF;
                end
            end
            DIFF: begin
                diff_next  = diff_red;
                hist_we    = 1'b1;
                ptr_next   = ptr_reg + 1'b1;
                cnt_next   = '0;
                state_next = SWEEP;
            end
            SWEEP: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_K) begin
                    drain_next = '0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_next = drain_reg + 1'b1;
                if (drain_reg == LAST_D) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign rd_addr  = (state_reg == SWEEP) ? cnt_reg : '0;
    assign align_in = {(state_reg == SWEEP), rd_addr};

    sdft_delay_buf #(
        .WIDTH (AW + 1),
        .DEPTH (RD_LATENCY)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   (align_in),
        .dout  (align_out)
    );

    assign bus.o_ready       = (state_reg == IDLE);
    assign bus.o_rd_addr     = rd_addr;
    assign bus.o_sample_diff = diff_reg;
    assign bus.o_idx         = align_out[AW-1:0];
    assign bus.o_wr_en       = align_out[AW];
    assign bus.o_clr_en      = clr_en_reg;
    assign bus.o_clr_addr    = cnt_reg;
    assign bus.o_frame_done  = (state_reg == DRAIN) && (drain_reg == LAST_D);

endmodule

// File: tb/tb_sdft_sequencer.sv
// Directed bench for sdft_sequencer at FFT_SIZE=8, RD_LATENCY=1, SPU_LATENCY=3.
module tb_sdft_sequencer;
    import sdft_pkg::*;

    localparam int W     = 16;
    localparam int N     = 8;
    localparam int RL    = 1;
    localparam int SL    = 3;
    localparam int FRAME = 2 + N + RL + SL;
    localparam int NTAB  = 26;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdft_sequencer_if #(.WORD_WIDTH(W), .FFT_SIZE(N)) bus ();

    sdft_sequencer #(
        .WORD_WIDTH  (W),
        .FFT_SIZE    (N),
        .RD_LATENCY  (RL),
        .SPU_LATENCY (SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int  samp  [NTAB];
    int  expd  [NTAB];
    bit  holdv [NTAB];

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Entered just after reset release; returns at the first negedge showing o_ready.
    task automatic init_check();
        int clr_cnt = 0;
        bit got_ready = 1'b0;
        for (int c = 0; c < 4 * N && !got_ready; c++) begin
            @(negedge clk);
            check("init_wr_en", int'(bus.o_wr_en), 0);
            if (bus.o_clr_en) begin
                check("clr_addr", int'(bus.o_clr_addr), clr_cnt);
                clr_cnt++;
            end
            got_ready = bus.o_ready;
            if (got_ready) check("clr_off_at_ready", int'(bus.o_clr_en), 0);
        end
        check("clr_cycles", clr_cnt, N);
        check("init_ready", int'(got_ready), 1);
        $display("init: %0d clear cycles, ready=%0d", clr_cnt, got_ready);
    endtask

    // Entered at a negedge; checks one full frame cycle by cycle after acceptance.
    task automatic send(input int sample, input int exp_diff, input bit hold);
        int waitc = 0;
        bus.i_sample = W'(sample);
        bus.i_valid  = 1'b1;
        while (!bus.o_ready && waitc < 4 * FRAME) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_wait", int'(bus.o_ready), 1);
        @(posedge clk);
        #1;
        if (!hold) bus.i_valid = 1'b0;
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            check("ready", int'(bus.o_ready), int'(n == FRAME));
            check("wr_en", int'(bus.o_wr_en), int'(n >= 2 + RL && n <= 1 + N + RL));
            check("frame_done", int'(bus.o_frame_done), int'(n == 1 + N + RL + SL));
            if (n >= 2 && n <= N + 1) check("rd_addr", int'(bus.o_rd_addr), n - 2);
            if (n >= 2 + RL && n <= 1 + N + RL) check("idx", int'(bus.o_idx), n - 2 - RL);
            if (n >= 2) check("diff", int'(bus.o_sample_diff), exp_diff);
        end
        $display("sample %0d: diff %0d expected %0d hold=%0d", sample,
                 int'(bus.o_sample_diff), exp_diff, hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NTAB; i++) begin
            samp[i]  = 0;
            expd[i]  = 0;
            holdv[i] = 1'b0;
        end
        samp[0]  = 100;    expd[0]  = 100;
        for (int i = 1; i <= 7; i++) holdv[i] = 1'b1;
        samp[8]  = 30;     expd[8]  = -70;
        samp[9]  = -32768; expd[9]  = -32768;
        expd[16] = -30;
        samp[17] = 32767;
        samp[24] = 500;    expd[24] = 500;
        samp[25] = -32768;
`ifdef SDFT_DIFF_SAT_EN
        expd[17] = 32767;
        expd[25] = -32768;
`else
        expd[17] = -1;
        expd[25] = 1;
`endif

        bus.i_sample = '0;
        bus.i_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(bus.o_ready), 0);
        check("rst_wr_en", int'(bus.o_wr_en), 0);
        check("rst_clr_en", int'(bus.o_clr_en), 0);
        check("rst_frame_done", int'(bus.o_frame_done), 0);
        check("rst_rd_addr", int'(bus.o_rd_addr), 0);
        check("rst_idx", int'(bus.o_idx), 0);
        check("rst_clr_addr", int'(bus.o_clr_addr), 0);
        check("rst_diff", int'(bus.o_sample_diff), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        init_check();
        for (int i = 0; i < NTAB; i++) send(samp[i], expd[i], holdv[i]);

        // Abort a sweep with reset at k=3.
        bus.i_sample = W'(77);
        bus.i_valid  = 1'b1;
        check("abort_ready", int'(bus.o_ready), 1);
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_rd_addr", int'(bus.o_rd_addr), 3);
        check("abort_wr_en_before", int'(bus.o_wr_en), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_wr_en", int'(bus.o_wr_en), 0);
        check("abort_ready_low", int'(bus.o_ready), 0);
        $display("reset during sweep: wr_en=%0d", bus.o_wr_en);
        reset = 1'b0;

        init_check();
        send(-1234, -1234, 1'b0);
        send(1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
